// File: rtl/tdp18k_fifo_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdp18k_fifo_reader_pkg
// Brief    : Read-mode encodings, pack-state type and byte-lane helpers.
// Revision : 1.0
// ============================================================================
package tdp18k_fifo_reader_pkg;

    localparam logic [2:0] MODE_1  = 3'b101;
    localparam logic [2:0] MODE_2  = 3'b110;
    localparam logic [2:0] MODE_4  = 3'b100;
    localparam logic [2:0] MODE_9  = 3'b001;
    localparam logic [2:0] MODE_18 = 3'b010;

    typedef enum logic [0:0] {
        PK_LO = 1'b0,
        PK_HI = 1'b1
    } pk_state_t;

    // Only MODE_9 packs; every other encoding is drained as full 18-bit words.
    function automatic logic rmode_is_pack9(input logic [2:0] m);
        logic r;
        case (m)
            MODE_9:                          r = 1'b1;
            MODE_1, MODE_2, MODE_4, MODE_18: r = 1'b0;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [8:0] byte_lane(input logic [17:0] d);
        return {d[16], d[7:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdp18k_fifo_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : tdp18k_fifo_reader_if
// Brief    : FIFO read-port and output-stream signals of the drain engine.
// Revision : 1.0
// ============================================================================
interface tdp18k_fifo_reader_if #(
    parameter int SKID_DEPTH = 2
);
    localparam int LW = $clog2(SKID_DEPTH + 1);

    logic [2:0]    RMODE_i;
    logic          FLUSH_i;
    logic          FIFO_EMPTY_i;
    logic          FIFO_EPO_i;
    logic          FIFO_UNDERRUN_i;
    logic [17:0]   FIFO_RDATA_i;
    logic          FIFO_REN_o;
    logic          FIFO_FLUSH_no;
    logic [17:0]   M_DATA_o;
    logic          M_VALID_o;
    logic          M_READY_i;
    logic [LW-1:0] LEVEL_o;
    logic          ERR_o;

    modport master (
        input  RMODE_i, FLUSH_i, FIFO_EMPTY_i, FIFO_EPO_i, FIFO_UNDERRUN_i,
               FIFO_RDATA_i, M_READY_i,
        output FIFO_REN_o, FIFO_FLUSH_no, M_DATA_o, M_VALID_o, LEVEL_o, ERR_o
    );

    modport slave (
        output RMODE_i, FLUSH_i, FIFO_EMPTY_i, FIFO_EPO_i, FIFO_UNDERRUN_i,
               FIFO_RDATA_i, M_READY_i,
        input  FIFO_REN_o, FIFO_FLUSH_no, M_DATA_o, M_VALID_o, LEVEL_o, ERR_o
    );

endinterface
`default_nettype wire

// File: rtl/tdp18k_fifo_reader_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : tdp18k_fifo_reader_skid_buf
// Brief    : Small register FIFO with registered head output and occupancy.
// Revision : 1.0
// ============================================================================
module tdp18k_fifo_reader_skid_buf #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_count;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop      = pop & (r_count != '0);
    assign head_data  = r_mem[r_rd_ptr];
    assign head_valid = (r_count != '0);
    assign level      = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // The upstream issue rule must never let a return arrive into a full buffer.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !clear && r_count == LW'(DEPTH)));

endmodule
`default_nettype wire

// File: rtl/tdp18k_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tdp18k_fifo_reader
// Brief    : TDP18K sync-FIFO drain engine: read issue, 9-to-18 packing, flush.
// Revision : 1.0
// ============================================================================
module tdp18k_fifo_reader
    import tdp18k_fifo_reader_pkg::*;
#(
    parameter int SKID_DEPTH = 2
) (
    input  logic                 CLK_i,
    input  logic                 RST_ni,
    tdp18k_fifo_reader_if.master bus
);
    localparam int LW = $clog2(SKID_DEPTH + 1);

    logic          r_inflight;
    logic          r_err;
    logic          r_mode_loaded;
    logic [1:0]    r_flush_cnt;
    logic [2:0]    r_mode;
    logic [8:0]    r_lo;
    pk_state_t     r_pk_state;
    pk_state_t     w_pk_next;
    logic          w_mode9;
    logic          w_ret;
    logic          w_pop;
    logic          w_push;
    logic          w_flush_busy;
    logic          w_ren;
    logic          w_head_valid;
    logic [8:0]    w_byte;
    logic [17:0]   w_push_data;
    logic [17:0]   w_head_data;
    logic [LW-1:0] w_level;

    assign w_mode9      = rmode_is_pack9(r_mode);
    assign w_ret        = r_inflight & ~bus.FLUSH_i;
    assign w_byte       = byte_lane(bus.FIFO_RDATA_i);
    assign w_pop        = w_head_valid & bus.M_READY_i;
    assign w_flush_busy = bus.FLUSH_i | (r_flush_cnt != 2'd0);

    // EPO with a read in flight means the flags have not yet caught up with the last word.
    assign w_ren = RST_ni & ~bus.FIFO_EMPTY_i & ~(bus.FIFO_EPO_i & r_inflight) & ~w_flush_busy
                 & ((int'(w_level) + int'(r_inflight)) < (SKID_DEPTH + int'(w_pop)));

    always_ff @(posedge CLK_i or negedge RST_ni) begin
        if (!RST_ni) begin
            r_inflight    <= 1'b0;
            r_err         <= 1'b0;
            r_flush_cnt   <= 2'd0;
            r_mode        <= MODE_18;
            r_mode_loaded <= 1'b0;
            r_lo          <= '0;
        end else begin
            r_inflight    <= w_ren;
            r_mode_loaded <= 1'b1;
            if (!r_mode_loaded || bus.FLUSH_i) r_mode <= bus.RMODE_i;
            if (bus.FLUSH_i) begin
                r_flush_cnt <= 2'd3;
                r_err       <= 1'b0;
            end else begin
                if (r_flush_cnt != 2'd0) r_flush_cnt <= r_flush_cnt - 2'd1;
                if (bus.FIFO_UNDERRUN_i) r_err <= 1'b1;
            end
            if (w_ret && w_mode9 && r_pk_state == PK_LO) r_lo <= w_byte;
        end
    end

    always_ff @(posedge CLK_i or negedge RST_ni) begin
        if (!RST_ni)           r_pk_state <= PK_LO;
        else if (bus.FLUSH_i)  r_pk_state <= PK_LO;
        else                   r_pk_state <= w_pk_next;
    end

    always_comb begin
        w_pk_next = r_pk_state;
        if (w_ret && w_mode9) w_pk_next = (r_pk_state == PK_LO) ? PK_HI : PK_LO;
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_data = bus.FIFO_RDATA_i;
        if (w_ret) begin
            if (!w_mode9) begin
                w_push = 1'b1;
            end else if (r_pk_state == PK_HI) begin
                w_push      = 1'b1;
                w_push_data = {w_byte[8], r_lo[8], w_byte[7:0], r_lo[7:0]};
            end
        end
    end

    tdp18k_fifo_reader_skid_buf #(
        .WIDTH (18),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk        (CLK_i),
        .rst_n      (RST_ni),
        .clear      (bus.FLUSH_i),
        .push       (w_push),
        .push_data  (w_push_data),
        .pop        (w_pop),
        .head_data  (w_head_data),
        .head_valid (w_head_valid),
        .level      (w_level)
    );

    // FLUSH_ni is held low for the two cycles following the request.
    assign bus.FIFO_FLUSH_no = ~r_flush_cnt[1];
    assign bus.FIFO_REN_o    = w_ren;
    assign bus.M_DATA_o      = w_head_data;
    assign bus.M_VALID_o     = w_head_valid;
    assign bus.LEVEL_o       = w_level;
    assign bus.ERR_o         = r_err;

endmodule
`default_nettype wire
